// File: rtl/frame_diff_engine.sv
// frame_diff_engine: streaming frame-difference / motion-mask core.
// Keeps the previous frame in an internal read-first RAM. Each valid pixel
// reads the co-located previous pixel and overwrites it with the current one.
// The block outputs either |cur - prev| on all three channels or a binary
// mask (all ones when the difference exceeds the threshold).
// Optional feature: define FRAME_DIFF_MOTION_COUNT_EN to build the per-frame
// motion-pixel counter. Without it, o_motion_count is tied to 0.
module frame_diff_engine #(
  parameter int PIX_W    = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DEPTH    = H_ACTIVE * V_ACTIVE,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     i_gray,
  input  logic                 i_vid_hsync,
  input  logic                 i_vid_vsync,
  input  logic                 i_vid_VDE,
  input  logic                 i_mode,
  input  logic [PIX_W-1:0]     i_threshold,
  output logic [3*PIX_W-1:0]   o_vid_data,
  output logic                 o_vid_hsync,
  output logic                 o_vid_vsync,
  output logic                 o_vid_VDE,
  output logic                 o_frame_done,
  output logic [CNT_W-1:0]     o_motion_count,
  output logic                 o_overrun
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3*PIX_W-1:0] ALL_ONES = {3*PIX_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  state_t            r_state, w_state_next;
  logic              r_vsync_q;
  logic              w_rise;
  logic [CNT_W-1:0]  r_addr, w_addr_cur, w_addr_next;
  logic              w_in_range;
  logic              w_we, w_run_pix, w_ovf;

  logic [PIX_W-1:0]  r_mem [0:DEPTH-1];
  logic [PIX_W-1:0]  r_prev;

  // Stage 1 registers
  logic [PIX_W-1:0]  r_gray_s1, r_thr_s1;
  logic              r_run_s1, r_mode_s1, r_hs_s1, r_vs_s1, r_vde_s1;
  // Stage 2 registers
  logic [3*PIX_W-1:0] r_data_s2;
  logic              r_hs_s2, r_vs_s2, r_vde_s2;
  logic              r_frame_done, r_overrun;

  logic [PIX_W:0]    w_sub;
  logic [PIX_W-1:0]  w_diff;
  logic              w_over_thr;
  logic [3*PIX_W-1:0] w_pix_out;

  // A frame starts on the rising edge of vsync; the address restarts at 0
  // in that same cycle, so a coincident pixel belongs to the new frame.
  assign w_rise     = i_vid_vsync & ~r_vsync_q;
  assign w_addr_cur = w_rise ? '0 : r_addr;
  assign w_in_range = (w_addr_cur < CNT_W'(DEPTH));

  // Next state plus per-pixel write/difference qualification for this cycle
  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    w_run_pix    = 1'b0;
    w_ovf        = 1'b0;
    w_addr_next  = w_addr_cur;
    case (r_state)
      S_IDLE:  if (w_rise) w_state_next = S_PRIME;
      S_PRIME: if (w_rise) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
    if (i_vid_VDE && (w_state_next != S_IDLE)) begin
      if (w_in_range) begin
        w_we        = 1'b1;
        w_run_pix   = (w_state_next == S_RUN);
        w_addr_next = w_addr_cur + CNT_W'(1);
      end else begin
        w_ovf = 1'b1;  // address saturated: drop the pixel
      end
    end
  end

  // State, vsync history and pixel address registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_vsync_q <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_vsync_q <= i_vid_vsync;
      r_addr    <= w_addr_next;
    end
  end

  // Frame store: read-first, registered read; contents survive reset
  always_ff @(posedge clk) begin
    if (w_in_range) r_prev <= r_mem[w_addr_cur[AW-1:0]];
    if (w_we)       r_mem[w_addr_cur[AW-1:0]] <= i_gray;
  end

  // Stage 1: capture the pixel, its controls and syncs alongside the RAM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gray_s1    <= '0;
      r_thr_s1     <= '0;
      r_run_s1     <= 1'b0;
      r_mode_s1    <= 1'b0;
      r_hs_s1      <= 1'b0;
      r_vs_s1      <= 1'b0;
      r_vde_s1     <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_gray_s1    <= i_gray;
      r_thr_s1     <= i_threshold;
      r_run_s1     <= w_run_pix;
      r_mode_s1    <= i_mode;
      r_hs_s1      <= i_vid_hsync;
      r_vs_s1      <= i_vid_vsync;
      r_vde_s1     <= i_vid_VDE;
      r_frame_done <= w_rise & (r_state != S_IDLE);
      if (w_ovf) r_overrun <= 1'b1;
    end
  end

  // Absolute difference via a PIX_W+1 bit subtraction; the sign bit picks
  // the operand order so the magnitude always fits PIX_W bits.
  assign w_sub      = {1'b0, r_gray_s1} - {1'b0, r_prev};
  assign w_diff     = w_sub[PIX_W] ? (r_prev - r_gray_s1) : w_sub[PIX_W-1:0];
  assign w_over_thr = (w_diff > r_thr_s1);
  assign w_pix_out  = !r_run_s1 ? '0 :
                      r_mode_s1 ? (w_over_thr ? ALL_ONES : '0) :
                                  {3{w_diff}};

  // Stage 2: output pixel and delayed syncs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_s2 <= '0;
      r_hs_s2   <= 1'b0;
      r_vs_s2   <= 1'b0;
      r_vde_s2  <= 1'b0;
    end else begin
      r_data_s2 <= w_pix_out;
      r_hs_s2   <= r_hs_s1;
      r_vs_s2   <= r_vs_s1;
      r_vde_s2  <= r_vde_s1;
    end
  end

`ifdef FRAME_DIFF_MOTION_COUNT_EN
  logic [CNT_W-1:0] r_work_cnt, r_motion_cnt;
  logic             w_hit;

  // w_hit belongs to the pixel captured one cycle earlier, so on a frame
  // boundary it still counts toward the frame being closed.
  assign w_hit = r_run_s1 & w_over_thr;

  // Working motion counter, latched and cleared at each frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work_cnt   <= '0;
      r_motion_cnt <= '0;
    end else if (w_rise) begin
      r_motion_cnt <= r_work_cnt + CNT_W'(w_hit);
      r_work_cnt   <= '0;
    end else if (w_hit) begin
      r_work_cnt   <= r_work_cnt + CNT_W'(1);
    end
  end

  assign o_motion_count = r_motion_cnt;
`else
  assign o_motion_count = '0;
`endif

  assign o_vid_data   = r_data_s2;
  assign o_vid_hsync  = r_hs_s2;
  assign o_vid_vsync  = r_vs_s2;
  assign o_vid_VDE    = r_vde_s2;
  assign o_frame_done = r_frame_done;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_frame_diff_engine.sv
// Directed testbench for frame_diff_engine with a scoreboard queue.
module tb_frame_diff_engine;
  localparam int PIX_W = 8;
  localparam int H_ACT = 4;
  localparam int V_ACT = 2;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef FRAME_DIFF_MOTION_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [PIX_W-1:0]    i_gray = '0;
  logic                i_vid_hsync = 1'b0;
  logic                i_vid_vsync = 1'b0;
  logic                i_vid_VDE = 1'b0;
  logic                i_mode = 1'b0;
  logic [PIX_W-1:0]    i_threshold = '0;
  logic [3*PIX_W-1:0]  o_vid_data;
  logic                o_vid_hsync, o_vid_vsync, o_vid_VDE;
  logic                o_frame_done;
  logic [CNT_W-1:0]    o_motion_count;
  logic                o_overrun;

  always #5 clk = ~clk;

  frame_diff_engine #(
    .PIX_W(PIX_W), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .i_gray(i_gray), .i_vid_hsync(i_vid_hsync),
    .i_vid_vsync(i_vid_vsync), .i_vid_VDE(i_vid_VDE), .i_mode(i_mode),
    .i_threshold(i_threshold), .o_vid_data(o_vid_data), .o_vid_hsync(o_vid_hsync),
    .o_vid_vsync(o_vid_vsync), .o_vid_VDE(o_vid_VDE), .o_frame_done(o_frame_done),
    .o_motion_count(o_motion_count), .o_overrun(o_overrun)
  );

  // Scoreboard entry: {hsync, vsync, VDE, data}
  typedef logic [3*PIX_W+2:0] exp_t;
  exp_t sb_q[$];

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "reset";

  // Reference model of the frame store and frame bookkeeping
  logic [PIX_W-1:0] m_mem [DEPTH];
  int   m_state  = 0;   // 0 idle, 1 prime, 2 run
  int   m_addr   = 0;
  int   m_count  = 0;
  int   m_motion = 0;
  logic m_vs_q   = 1'b0;
  logic m_ovr    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  // One clock: model the current inputs, push the expectation, advance,
  // then compare the output that is due now (two cycles of latency).
  task automatic step();
    logic rise, fd;
    int   st, addr;
    logic [PIX_W-1:0] prev, d;
    logic [3*PIX_W-1:0] data;
    exp_t e;
    rise = i_vid_vsync && !m_vs_q;
    st   = m_state;
    if (rise) st = (m_state == 0) ? 1 : 2;
    fd   = rise && (m_state != 0);
    addr = rise ? 0 : m_addr;
    if (rise) begin
      m_motion = COUNT_EN ? m_count : 0;
      m_count  = 0;
    end
    data = '0;
    if (i_vid_VDE && st != 0) begin
      if (addr < DEPTH) begin
        prev = m_mem[addr];
        if (st == 2) begin
          d = (i_gray > prev) ? (i_gray - prev) : (prev - i_gray);
          if (d > i_threshold) m_count++;
          if (i_mode) data = (d > i_threshold) ? {3*PIX_W{1'b1}} : '0;
          else        data = {d, d, d};
        end
        m_mem[addr] = i_gray;
        addr++;
      end else begin
        m_ovr = 1'b1;
      end
    end
    m_state = st;
    m_addr  = addr;
    m_vs_q  = i_vid_vsync;
    sb_q.push_back({i_vid_hsync, i_vid_vsync, i_vid_VDE, data});
    @(posedge clk);
    #1;
    if (sb_q.size() > 1) begin
      e = sb_q.pop_front();
      check("pipe", 32'({o_vid_hsync, o_vid_vsync, o_vid_VDE, o_vid_data}), 32'(e));
      $display("[TB] %s out hs=%b vs=%b vde=%b data=%h", phase, o_vid_hsync, o_vid_vsync, o_vid_VDE, o_vid_data);
    end
    check("frame_done", 32'(o_frame_done), 32'(fd));
    check("motion_count", 32'(o_motion_count), m_motion);
    check("overrun", 32'(o_overrun), 32'(m_ovr));
  endtask

  task automatic pix(input logic [PIX_W-1:0] g);
    i_gray = g; i_vid_VDE = 1'b1; step();
  endtask

  task automatic gap(input int n);
    i_vid_VDE = 1'b0; i_gray = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  // vsync held high two cycles: only the first one is a rising edge
  task automatic vsync_pulse();
    i_vid_VDE = 1'b0; i_vid_vsync = 1'b1;
    step(); step();
    i_vid_vsync = 1'b0;
    step();
  endtask

  // n pixels alternating a/b, with an hsync blanking cycle after each line
  task automatic frame(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      pix((k % 2 == 0) ? a : b);
      if ((k % H_ACT) == H_ACT - 1) begin
        i_vid_VDE = 1'b0; i_vid_hsync = 1'b1; step(); i_vid_hsync = 1'b0;
      end
    end
  endtask

  task automatic reset_outputs_zero();
    check("rst_data", 32'(o_vid_data), 0);
    check("rst_syncs", 32'({o_vid_hsync, o_vid_vsync, o_vid_VDE}), 0);
    check("rst_frame_done", 32'(o_frame_done), 0);
    check("rst_motion", 32'(o_motion_count), 0);
    check("rst_overrun", 32'(o_overrun), 0);
  endtask

  // Asynchronous reset in the middle of a running stream
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 reset_outputs_zero();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    m_state = 0; m_addr = 0; m_count = 0; m_motion = 0; m_vs_q = 1'b0; m_ovr = 1'b0;
  endtask

  initial begin
    #1 reset_outputs_zero();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    phase = "idle";
    pix(8'h77); pix(8'h77); pix(8'h77); pix(8'h77); gap(2);

    phase = "prime";
    vsync_pulse(); frame(8'h40, 8'h40, 8); gap(2);

    phase = "absdiff";
    i_mode = 1'b0;
    vsync_pulse(); frame(8'h50, 8'h30, 8); gap(2);

    phase = "restore";
    vsync_pulse(); frame(8'h40, 8'h40, 8); gap(2);

    phase = "mask";
    i_mode = 1'b1; i_threshold = 8'h10;
    vsync_pulse(); frame(8'h50, 8'h51, 8); gap(2);

    phase = "overrun";
    i_mode = 1'b0;
    vsync_pulse();
    for (int k = 0; k < 10; k++) pix(8'h60);
    gap(2);
    vsync_pulse(); frame(8'h60, 8'h60, 8); gap(2);

    phase = "midreset";
    vsync_pulse();
    pix(8'h70); pix(8'h70); pix(8'h70);
    async_reset();

    phase = "after_rst";
    pix(8'hAA); pix(8'hAA); gap(2);
    vsync_pulse(); frame(8'h20, 8'h20, 8); gap(2);
    vsync_pulse(); frame(8'h28, 8'h18, 8); gap(2);
    i_mode = 1'b1; i_threshold = 8'h05;
    vsync_pulse(); frame(8'h30, 8'h22, 8); gap(2);
    vsync_pulse(); gap(3);

    phase = "drain";
    check("sb_depth", sb_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
